// File: rtl/tiny_cpu_pkg.sv
// Shared types and encodings for the tiny RV32I-subset core.
// Used by the sequencer, its decoder and the datapath.
package tiny_cpu_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_ILL  = 2'b01;
  localparam logic [1:0] FLT_TMO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    WB,
    HALT
  } seq_state_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier: ir -> type flags and rd.
// Shared between the sequencer and the datapath.
module seq_decode
  import tiny_cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_rtype,
  output logic        is_itype,
  output logic        is_nop,
  output logic        illegal,
  output logic [4:0]  rd
);

  assign rd = ir[11:7];

  always_comb begin
    is_rtype = 1'b0;
    is_itype = 1'b0;
    is_nop   = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      (ir == 32'h0):         is_nop   = 1'b1;
      (ir[6:0] == OP_RTYPE): is_rtype = 1'b1;
      (ir[6:0] == OP_ITYPE): is_itype = 1'b1;
      default:               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/writeback control FSM for the tiny core.
// Define CPU_SEQ_RETIRE_CNT_EN to add the retire_cnt output.
module cpu_sequencer
  import tiny_cpu_pkg::*;
#(
  parameter int ROM_DEPTH = 16,
  parameter int PC_W      = $clog2(ROM_DEPTH),
  parameter int FETCH_TMO = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            tick,
  input  logic            run,
  input  logic            step,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic            is_rtype,
  output logic            is_itype,
  output logic            busy,
  output logic [1:0]      fault
`ifdef CPU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]     retire_cnt
`endif
);

  localparam int TMO_W = $clog2(FETCH_TMO + 1);

  seq_state_t      state, state_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             step_pend;
  logic             is_nop, illegal;
  logic [4:0]       rd;
  logic [PC_W-1:0]  pc_inc;

  seq_decode u_dec (
    .ir       (ir),
    .is_rtype (is_rtype),
    .is_itype (is_itype),
    .is_nop   (is_nop),
    .illegal  (illegal),
    .rd       (rd)
  );

  assign imem_addr = pc;
  assign rf_waddr  = rd;
  assign tmo_hit   = (tmo_cnt == TMO_W'(FETCH_TMO - 1));
  // Wrap by compare so non-power-of-two ROM depths also work
  assign pc_inc    = (pc == PC_W'(ROM_DEPTH - 1)) ? '0 : pc + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (tick && (run || step || step_pend))
          state_d = FETCH;
      FETCH:
        if (tick) state_d = WAIT;
      WAIT:
        if (imem_ack)             state_d = DECODE;
        else if (tick && tmo_hit) state_d = HALT;
      DECODE:
        if (tick) begin
          if (illegal)     state_d = HALT;
          else if (is_nop) state_d = WB;
          else             state_d = EXEC;
        end
      EXEC:
        if (tick) state_d = WB;
      WB:
        if (tick) state_d = run ? FETCH : IDLE;
      HALT:
        state_d = HALT;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE) && (state != HALT);
    rf_we = (state == WB) && tick &&
            (is_rtype || is_itype) && (rd != 5'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      tmo_cnt   <= '0;
      fault     <= FLT_NONE;
      step_pend <= 1'b0;
    end else begin
      if (state == IDLE && step && !run)
        step_pend <= 1'b1;
      if (state == FETCH && tick) begin
        imem_req <= 1'b1;
        tmo_cnt  <= '0;
      end
      if (state == WAIT) begin
        if (imem_ack) begin
          ir       <= imem_rdata;
          imem_req <= 1'b0;
        end else if (tick) begin
          if (tmo_hit) begin
            imem_req <= 1'b0;
            fault    <= FLT_TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      end
      if (state == DECODE && tick && illegal)
        fault <= FLT_ILL;
      if (state == WB && tick) begin
        pc        <= pc_inc;
        step_pend <= 1'b0;
      end
    end
  end

`ifdef CPU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     retire_cnt <= '0;
    else if (state == WB && tick) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected writebacks queued
// as programs are set up, popped when rf_we fires.
module tb_cpu_sequencer;

  localparam int PC_W = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            tick = 1'b1;
  logic            run = 1'b0;
  logic            step = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic            is_rtype;
  logic            is_itype;
  logic            busy;
  logic [1:0]      fault;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [15:0]     retire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [16];
  logic [8:0]  exp_q [$];
  bit          ack_en  = 1'b1;
  bit          tick_rnd = 1'b0;

  cpu_sequencer #(
    .ROM_DEPTH (16),
    .PC_W      (PC_W),
    .FETCH_TMO (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tick       (tick),
    .run        (run),
    .step       (step),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .pc         (pc),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .is_rtype   (is_rtype),
    .is_itype   (is_itype),
    .busy       (busy),
    .fault      (fault)
`ifdef CPU_SEQ_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ROM responder: ack one cycle after req is seen
  always @(posedge CLK) begin
    #1;
    if (ack_en && imem_req && !imem_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = rom[imem_addr];
    end else begin
      imem_ack = 1'b0;
    end
    tick = tick_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge CLK) begin
    if (!RST && rf_we) begin
      if (exp_q.size() == 0)
        check("rf_we_unexpected", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      else
        check("wb_pc_rd", {23'd0, pc, rf_waddr}, {23'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    @(negedge CLK);
    while (busy !== lvl && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pc(input logic [PC_W-1:0] v, input string tag);
    int n = 0;
    @(negedge CLK);
    while (pc !== v && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge CLK);
    while (imem_req !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check({tag, "_pc"},    {28'd0, pc}, 32'd0);
    check({tag, "_ir"},    ir, 32'd0);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_fault"}, {30'd0, fault}, 32'd0);
    RST = 1'b0;
  endtask

  initial begin
    int req_cycles;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0]  = 32'h0050_0093;
    rom[1]  = 32'h0030_0113;
    rom[2]  = 32'h0020_81B3;
    rom[4]  = 32'h0010_0213;
    rom[15] = 32'h0000_0013;

    @(negedge CLK);
    do_reset("rst");

    // run program; drop run while word 3 is in flight
    exp_q.push_back({4'd0, 5'd1});
    exp_q.push_back({4'd1, 5'd2});
    exp_q.push_back({4'd2, 5'd3});
    run = 1'b1;
    wait_pc(4'd3, "t1_pc3");
    run = 1'b0;
    wait_busy(1'b0, "t1_idle");
    check("t1_pc", {28'd0, pc}, 32'd4);
    check("t1_q", exp_q.size(), 32'd0);
    check("t1_nop_ir", ir, 32'd0);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    check("t1_retire", {16'd0, retire_cnt}, 32'd4);
`endif

    // single step with sparse ticks; second pulse while busy ignored
    tick_rnd = 1'b1;
    exp_q.push_back({4'd4, 5'd4});
    pulse_step();
    wait_busy(1'b1, "t2_busy");
    pulse_step();
    wait_busy(1'b0, "t2_idle");
    check("t2_pc", {28'd0, pc}, 32'd5);
    repeat (12) @(negedge CLK);
    check("t2_pc_hold", {28'd0, pc}, 32'd5);
    check("t2_busy_hold", {31'd0, busy}, 32'd0);
    check("t2_q", exp_q.size(), 32'd0);
    tick_rnd = 1'b0;

    // wrap 15 -> 0, rd=0 ADDI at 15 retires silently
    exp_q.push_back({4'd0, 5'd1});
    run = 1'b1;
    wait_pc(4'd0, "t5_wrap");
    run = 1'b0;
    check("t5_addr0", {28'd0, imem_addr}, 32'd0);
    wait_busy(1'b0, "t5_idle");
    check("t5_pc", {28'd0, pc}, 32'd1);
    check("t5_ir", ir, 32'h0050_0093);
    check("t5_itype", {30'd0, is_itype, is_rtype}, 32'd2);
    check("t5_q", exp_q.size(), 32'd0);

    // illegal opcode halts
    rom[1] = 32'h0000_007F;
    pulse_step();
    wait_busy(1'b1, "t3_busy");
    wait_busy(1'b0, "t3_halt");
    check("t3_fault", {30'd0, fault}, 32'd1);
    check("t3_pc", {28'd0, pc}, 32'd1);
    pulse_step();
    repeat (10) @(negedge CLK);
    check("t3_req", {31'd0, imem_req}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_pc_hold", {28'd0, pc}, 32'd1);
    do_reset("t3_rst");

    // fetch timeout: ack never comes
    ack_en = 1'b0;
    run = 1'b1;
    wait_busy(1'b1, "t4_busy");
    req_cycles = 0;
    for (int n = 0; n < 300 && busy; n++) begin
      if (imem_req) req_cycles++;
      @(negedge CLK);
    end
    check("t4_req_cycles", req_cycles, 32'd3);
    check("t4_fault", {30'd0, fault}, 32'd2);
    check("t4_req", {31'd0, imem_req}, 32'd0);
    check("t4_pc", {28'd0, pc}, 32'd0);
    run = 1'b0;
    ack_en = 1'b1;
    do_reset("t4_rst");

    // async reset while a fetch is outstanding
    rom[1] = 32'h0030_0113;
    exp_q.push_back({4'd0, 5'd1});
    run = 1'b1;
    wait_pc(4'd1, "t6_pc1");
    wait_req("t6_req");
    RST = 1'b1;
    #1;
    check("t6_req", {31'd0, imem_req}, 32'd0);
    check("t6_we", {31'd0, rf_we}, 32'd0);
    check("t6_pc", {28'd0, pc}, 32'd0);
    check("t6_ir", ir, 32'd0);
    @(negedge CLK);
    exp_q.push_back({4'd0, 5'd1});
    exp_q.push_back({4'd1, 5'd2});
    RST = 1'b0;
    wait_req("t6_refetch");
    check("t6_addr", {28'd0, imem_addr}, 32'd0);
    wait_pc(4'd1, "t6_pc1b");
    run = 1'b0;
    wait_busy(1'b0, "t6_idle");
    check("t6_pc_end", {28'd0, pc}, 32'd2);
    check("t6_q", exp_q.size(), 32'd0);
    check("t6_fault", {30'd0, fault}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
